// File: rtl/hazard_control_unit_types_pkg.sv
// Shared types for the hazard scoreboard unit: FSM encoding, scoreboard entry
// layout and sizing limits.
package hazard_control_unit_types_pkg;

  localparam int HCU_DEPTH_MAX = 6;
  localparam int HCU_REGW_MAX  = 8;
  localparam int HCU_AGEW      = $clog2(HCU_DEPTH_MAX);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEMWAIT  = 2'd1,
    REDIRECT = 2'd2
  } hcu_state_t;

  // wsel is stored at the widest supported index width and zero-extended
  typedef struct packed {
    logic                    valid;
    logic [HCU_REGW_MAX-1:0] wsel;
    logic                    load;
    logic [HCU_AGEW-1:0]     age;
  } sb_entry_t;

endpackage

// File: rtl/hazard_scoreboard_unit_if.sv
// Decode/status inputs and enable/flush outputs of the hazard scoreboard unit;
// hc is the unit's view, tb the driver's view.
interface hazard_scoreboard_unit_if #(
  parameter int REGW = 5,
  parameter int CNTW = 16
);
  logic            ihit, dhit, dREQ, redirect;
  logic [REGW-1:0] IDrs, IDrt, IDwsel;
  logic            IDrsuse, IDrtuse, IDwen, IDload;
  logic            PCEN, IFIDEN, IDEXEN, EXMMEN, MMWBEN;
  logic            IFIDflush, IDEXflush, EXMMflush;
  logic [CNTW-1:0] stall_cnt;
  logic [1:0]      state_o;

  modport hc (
    input  ihit, dhit, dREQ, redirect, IDrs, IDrt, IDwsel,
           IDrsuse, IDrtuse, IDwen, IDload,
    output PCEN, IFIDEN, IDEXEN, EXMMEN, MMWBEN,
           IFIDflush, IDEXflush, EXMMflush, stall_cnt, state_o
  );

  modport tb (
    output ihit, dhit, dREQ, redirect, IDrs, IDrt, IDwsel,
           IDrsuse, IDrtuse, IDwen, IDload,
    input  PCEN, IFIDEN, IDEXEN, EXMMEN, MMWBEN,
           IFIDflush, IDEXflush, EXMMflush, stall_cnt, state_o
  );
endinterface

// File: rtl/hcu_scoreboard.sv
// In-flight write scoreboard (entry 0 = EX) with RAW match against the ID stage.
// HCU_FORWARD_EN selects load-use-only stalls; otherwise full interlock.
module hcu_scoreboard
  import hazard_control_unit_types_pkg::*;
#(
  parameter int REGW  = 5,
  parameter int DEPTH = 3,
  parameter int LDLAT = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            shift_i,
  input  logic            issue_i,
  input  logic            kill_i,
  input  logic [REGW-1:0] rs_i,
  input  logic            rsuse_i,
  input  logic [REGW-1:0] rt_i,
  input  logic            rtuse_i,
  input  logic [REGW-1:0] wsel_i,
  input  logic            wen_i,
  input  logic            load_i,
  output logic            raw_stall_o
);

`ifdef HCU_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  // An entry of age a sits a+1 stages ahead of ID; forwarding only covers a
  // load once it is at least LDLAT stages further on.
  localparam int WIN = FWD ? LDLAT : DEPTH;

  sb_entry_t [DEPTH-1:0] sb_q, sb_d;

  always_comb begin
    sb_d = sb_q;
    if (shift_i) begin
      sb_d[0] = '0;
      if (issue_i) begin
        sb_d[0].valid = wen_i && (wsel_i != '0);
        sb_d[0].wsel  = HCU_REGW_MAX'(wsel_i);
        sb_d[0].load  = load_i;
      end
      for (int i = 1; i < DEPTH; i++) begin
        sb_d[i]     = sb_q[i-1];
        sb_d[i].age = sb_q[i-1].age + 1'b1;
      end
      if (kill_i) sb_d[1].valid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state is written with non-blocking assignments only.
    if (!rst_n) sb_q <= '0;
    else        sb_q <= sb_d;
  end

  always_comb begin
    logic hit;
    raw_stall_o = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      hit = sb_q[i].valid &&
            ((rsuse_i && rs_i != '0 && sb_q[i].wsel == HCU_REGW_MAX'(rs_i)) ||
             (rtuse_i && rt_i != '0 && sb_q[i].wsel == HCU_REGW_MAX'(rt_i)));
      if (hit && (sb_q[i].load || !FWD) && (int'(sb_q[i].age) < WIN))
        raw_stall_o = 1'b1;
    end
  end

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// Pipeline hazard control: memory-wait/redirect FSM, stage enable/flush decode
// and stall counter around hcu_scoreboard. Build option: HCU_FORWARD_EN.
module hazard_scoreboard_unit
  import hazard_control_unit_types_pkg::*;
#(
  parameter int REGW  = 5,
  parameter int DEPTH = 3,
  parameter int LDLAT = 1,
  parameter int CNTW  = 16
) (
  input  logic                 CLK,
  input  logic                 nRST,
  hazard_scoreboard_unit_if.hc bus
);

  hcu_state_t      state_q;
  logic [CNTW-1:0] stall_cnt_q;
  logic            raw_stall, mem_wait;
  logic            pcen, ifiden, idexen, exmmen, mmwben;
  logic            ifidflush, idexflush, exmmflush;

  hcu_scoreboard #(
    .REGW (REGW),
    .DEPTH(DEPTH),
    .LDLAT(LDLAT)
  ) u_sb (
    .clk        (CLK),
    .rst_n      (nRST),
    .shift_i    (idexen),
    .issue_i    (idexen && !idexflush),
    .kill_i     (exmmflush),
    .rs_i       (bus.IDrs),
    .rsuse_i    (bus.IDrsuse),
    .rt_i       (bus.IDrt),
    .rtuse_i    (bus.IDrtuse),
    .wsel_i     (bus.IDwsel),
    .wen_i      (bus.IDwen),
    .load_i     (bus.IDload),
    .raw_stall_o(raw_stall)
  );

  // The pipeline freezes from the first cycle the miss is seen, not only once
  // the FSM has reached MEMWAIT.
  assign mem_wait = !bus.dhit &&
                    ((state_q == RUN && bus.dREQ) || state_q == MEMWAIT);

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    {pcen, ifiden, idexen, exmmen, mmwben} = '0;
    {ifidflush, idexflush, exmmflush}      = '0;
    if (nRST && !mem_wait) begin
      {pcen, ifiden, idexen, exmmen, mmwben} = '1;
      if (state_q == REDIRECT) begin
        {ifidflush, idexflush, exmmflush} = '1;
      end else if (raw_stall) begin
        {pcen, ifiden} = '0;
        idexflush      = 1'b1;
      end else if (!bus.ihit) begin
        pcen      = 1'b0;
        ifidflush = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q     <= RUN;
      stall_cnt_q <= '0;
    end else begin
      case (state_q)
        RUN: begin
          if (bus.dREQ && !bus.dhit) state_q <= MEMWAIT;
          else if (bus.redirect)     state_q <= REDIRECT;
        end
        MEMWAIT: begin
          if (bus.dhit) state_q <= bus.redirect ? REDIRECT : RUN;
        end
        default: state_q <= RUN;
      endcase
      if (!pcen && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign bus.PCEN      = pcen;
  assign bus.IFIDEN    = ifiden;
  assign bus.IDEXEN    = idexen;
  assign bus.EXMMEN    = exmmen;
  assign bus.MMWBEN    = mmwben;
  assign bus.IFIDflush = ifidflush;
  assign bus.IDEXflush = idexflush;
  assign bus.EXMMflush = exmmflush;
  assign bus.stall_cnt = stall_cnt_q;
  assign bus.state_o   = state_q;

endmodule
